// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer: FSM state encoding and
// counter width helper.
package shift_seq_pkg;

    // FSM state encoding (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Width of a counter spanning n states; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_slot_timer.sv
// Bit-slot rate divider: counts DIV clocks per slot while running and raises
// slot_end_o on the last clock of each slot. Cleared by reset, by an explicit
// clear (word load or abort) and whenever the sequencer is not shifting.
module shift_slot_timer
    import shift_seq_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic slot_end_o
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    assign slot_end_o = run_i && (div_q == LAST);

    // Next divider count: restart on clear/idle, wrap at the slot end
    always_comb begin
        div_d = div_q;
        if (clear_i || !run_i) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + CW'(1);
        end
    end

    // Divider count register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: accepts a parallel word over valid/ready, shifts it
// out one bit per bit-slot on so, frames it with so_valid and a done pulse.
// Optional feature macro: SHIFT_PARITY_EN appends one even-parity bit-slot
// after the data bits.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = cnt_width(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             done_q, done_d;
`ifdef SHIFT_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             load;
    logic             run;
    logic             abort_hit;
    logic             slot_end;

    // sr holds the bits still waiting behind the one currently on so
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] sr_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign first_bit  = in_data[WIDTH-1];
            assign load_rest  = {in_data[WIDTH-2:0], 1'b0};
            assign next_bit   = sr_q[WIDTH-1];
            assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign first_bit  = in_data[0];
            assign load_rest  = {1'b0, in_data[WIDTH-1:1]};
            assign next_bit   = sr_q[0];
            assign sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign load      = in_valid && in_ready;
    assign run       = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign abort_hit = abort && run;

    assign so        = so_q;
    assign so_valid  = so_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    shift_slot_timer #(
        .DIV(DIV)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (load || abort_hit),
        .run_i     (run),
        .slot_end_o(slot_end)
    );

    // FSM next state plus shift register, bit counter and output framing
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bitcnt_d   = bitcnt_q;
        so_d       = so_q;
        so_valid_d = so_valid_q;
        done_d     = 1'b0;
`ifdef SHIFT_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sr_d       = load_rest;
                    bitcnt_d   = '0;
                    so_d       = first_bit;
                    so_valid_d = 1'b1;
`ifdef SHIFT_PARITY_EN
                    parity_d   = ^in_data;
`endif
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // abort wins over a slot end in the same cycle
                if (abort) begin
                    state_d    = ST_IDLE;
                    so_d       = 1'b0;
                    so_valid_d = 1'b0;
                end else if (slot_end) begin
                    if (bitcnt_q == BIT_LAST) begin
`ifdef SHIFT_PARITY_EN
                        state_d    = ST_PARITY;
                        so_d       = parity_q;
`else
                        state_d    = ST_DONE;
                        so_d       = 1'b0;
                        so_valid_d = 1'b0;
                        done_d     = 1'b1;
`endif
                    end else begin
                        sr_d     = sr_shifted;
                        so_d     = next_bit;
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end
`ifdef SHIFT_PARITY_EN
            ST_PARITY: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    so_d       = 1'b0;
                    so_valid_d = 1'b0;
                end else if (slot_end) begin
                    state_d    = ST_DONE;
                    so_d       = 1'b0;
                    so_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
`else
            ST_PARITY: begin
                // unreachable without the parity slot; recover to idle
                state_d    = ST_IDLE;
                so_d       = 1'b0;
                so_valid_d = 1'b0;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                so_d       = 1'b0;
                so_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any word in flight without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SHIFT_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bitcnt_q   <= bitcnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
`ifdef SHIFT_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: two instances (LSB-first DIV=1 and
// MSB-first DIV=3) share one stimulus stream and are each compared every cycle
// against a timing model based on the offset since the accepting edge.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int DA = 1;
    localparam int DB = 3;
`ifdef SHIFT_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LDA = (W + PAR) * DA;
    localparam int LDB = (W + PAR) * DB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         abort;
    logic [W-1:0] in_data;
    logic [1:0]   in_ready_w, so_w, so_valid_w, busy_w, done_w;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(W), .DIV(DA), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .abort(abort), .so(so_w[0]), .so_valid(so_valid_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    shift_seq_ctrl #(.WIDTH(W), .DIV(DB), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .abort(abort), .so(so_w[1]), .so_valid(so_valid_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    // ---------------- reference model ----------------
    bit           m_act [2];
    int           m_k   [2];
    logic [W-1:0] m_word[2];
    int           cyc;
    int           n_pass;
    int           n_total;

    function automatic int div_of(input int m);
        return (m == 0) ? DA : DB;
    endfunction

    // Bit sent in slot idx: data bits in wire order, then the parity slot
    function automatic logic bit_at(input int m, input int idx);
        logic [W-1:0] w;
        w = m_word[m];
        if (idx >= W) return ^w;
        if (m == 1) return w[W-1-idx];
        return w[idx];
    endfunction

    task automatic chk(input string name, input int m, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc %0d: got %b expected %b", name, m, cyc, act, exp);
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           ab;
        logic         so;
        logic         sv;
        logic         done;
        logic         rdy;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input bit v, input logic [W-1:0] d, input bit ab,
                                input logic so, input logic sv, input logic dn, input logic rdy);
        vec_t t;
        t.v = v; t.d = d; t.ab = ab; t.so = so; t.sv = sv; t.done = dn; t.rdy = rdy;
        return t;
    endfunction

    // One clock: drive inputs, compare both DUTs to the model, advance model
    task automatic step(input bit v, input logic [W-1:0] d, input bit ab, input bit r, input int ti);
        @(negedge clk);
        in_valid = v; in_data = d; abort = ab; rst = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            int   ld;
            int   off;
            logic e_so, e_sv, e_busy, e_done, e_rdy;
            ld = (W + PAR) * div_of(m);
            e_so = 1'b0; e_sv = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_rdy = !m_act[m] && !r;
            if (m_act[m]) begin
                off    = cyc - m_k[m];
                e_busy = 1'b1;
                e_sv   = (off < ld);
                e_done = (off == ld);
                if (e_sv) e_so = bit_at(m, off / div_of(m));
            end
            chk("so",       m, so_w[m],       e_so);
            chk("so_valid", m, so_valid_w[m], e_sv);
            chk("busy",     m, busy_w[m],     e_busy);
            chk("done",     m, done_w[m],     e_done);
            chk("in_ready", m, in_ready_w[m], e_rdy);
        end
        if (ti >= 0) begin
            chk("tbl_so",       0, so_w[0],       tbl[ti].so);
            chk("tbl_so_valid", 0, so_valid_w[0], tbl[ti].sv);
            chk("tbl_done",     0, done_w[0],     tbl[ti].done);
            chk("tbl_in_ready", 0, in_ready_w[0], tbl[ti].rdy);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            int ld;
            int off;
            ld = (W + PAR) * div_of(m);
            if (r) begin
                m_act[m] = 1'b0;
            end else if (m_act[m]) begin
                off = cyc - m_k[m];
                if ((ab && off < ld) || off == ld) m_act[m] = 1'b0;
            end else if (v) begin
                m_act[m]  = 1'b1;
                m_k[m]    = cyc + 1;
                m_word[m] = d;
                $display("cyc %0d dut%0d accept %b", cyc, m, d);
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < LDB + 3; i++) step(1'b0, '0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 1'b0; m_k[m] = 0; m_word[m] = '0;
        end

        // dut_a: 1011 LSB-first then an aborted 1111
        tbl[0] = mk(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[1] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SHIFT_PARITY_EN
        tbl[5] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[6] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        tbl[5] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        tbl[7]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        step(1'b0, '0, 1'b0, 1'b1, -1);   // reset state, in_ready low in reset

        for (int i = 0; i < 13; i++) step(tbl[i].v, tbl[i].d, tbl[i].ab, 1'b0, i);
        drain();

        // MSB-first, DIV=3: 1000 gives 1 for three clocks then zeros, done late
        step(1'b1, 4'b1000, 1'b0, 1'b0, -1);
        for (int t = 0; t <= LDB + 1; t++) begin
            #2;
            chk("t2_so",   1, so_w[1],   (t < DB) || (PAR == 1 && t >= W * DB && t < LDB));
            chk("t2_done", 1, done_w[1], t == LDB);
            step(1'b0, '0, 1'b0, 1'b0, -1);
        end
        drain();

        // in_valid held high: second word accepted only after done
        step(1'b1, 4'b1010, 1'b0, 1'b0, -1);
        for (int t = 0; t <= LDA + 1; t++) begin
            #2;
            chk("t3_ready", 0, in_ready_w[0], t == LDA + 1);
            chk("t3_sv",    0, so_valid_w[0], t < LDA);
            step(1'b1, 4'b0101, 1'b0, 1'b0, -1);
        end
        #2;
        chk("t3_second_sv", 0, so_valid_w[0], 1'b1);
        chk("t3_second_so", 0, so_w[0],       1'b1);
        drain();

        // reset together with abort mid-word, then a normal accept
        step(1'b1, 4'b1111, 1'b0, 1'b0, -1);
        step(1'b0, '0, 1'b0, 1'b0, -1);
        step(1'b0, '0, 1'b1, 1'b1, -1);
        #2;
        chk("t5_so",    0, so_w[0],       1'b0);
        chk("t5_sv",    0, so_valid_w[0], 1'b0);
        chk("t5_busy",  0, busy_w[0],     1'b0);
        chk("t5_done",  0, done_w[0],     1'b0);
        chk("t5_ready", 0, in_ready_w[0], 1'b0);
        step(1'b1, 4'b0101, 1'b0, 1'b0, -1);
        #2;
        chk("t5_new_sv", 0, so_valid_w[0], 1'b1);
        chk("t5_new_so", 0, so_w[0],       1'b1);
        drain();

        // randomized traffic with occasional abort and reset
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] rd;
            rd = W'($urandom);
            step(1'($urandom_range(0, 1)), rd, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
